// File: rtl/eclk_bus_ctrl_if.sv
// rtl/eclk_bus_ctrl_if.sv - CPU and CIA bus signals of the E-clock peripheral cycle controller
interface eclk_bus_ctrl_if;
    logic       req;
    logic       rnw;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       ack;
    logic       vma;
    logic       cia_sel;
    logic       cia_rnw;
    logic [7:0] cia_dout;
    logic [7:0] cia_din;

    modport slave (
        input  req, rnw, cpu_din, cia_din,
        output cpu_dout, ack, vma, cia_sel, cia_rnw, cia_dout
    );

    modport master (
        output req, rnw, cpu_din, cia_din,
        input  cpu_dout, ack, vma, cia_sel, cia_rnw, cia_dout
    );
endinterface

// File: rtl/eclk_bus_ctrl.sv
// rtl/eclk_bus_ctrl.sv - 6800-style E-clock synchronous peripheral cycle for the CIAs
// Advances on 7 MHz ticks only and flags any break in the one-hot E phase sequence.
module eclk_bus_ctrl #(
    parameter int VMA_PHASE = 3
) (
    input  logic                clk_28,
    input  logic                rst,
    input  logic                clk7p_en,
    input  logic [9:0]          eclk,
    output logic                phase_err,
    eclk_bus_ctrl_if.slave      bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_VMA,
        S_SEL,
        S_DONE
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       eclk_onehot;
    logic [3:0] phase_idx;
    logic [3:0] last_idx;
    logic [3:0] exp_idx;
    logic       last_valid;
    logic       hit_vma;
    logic       hit_e_rise;
    logic       hit_e_last;

    // A corrupted eclk must never match any phase, so every hit is gated by the one-hot test.
    always_comb begin
        eclk_onehot = (eclk != 10'd0) && ((eclk & (eclk - 10'd1)) == 10'd0);
        phase_idx   = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (eclk[i]) begin
                phase_idx = 4'(i);
            end
        end
        hit_vma    = eclk_onehot && eclk[VMA_PHASE];
        hit_e_rise = eclk_onehot && eclk[6];
        hit_e_last = eclk_onehot && eclk[9];
        exp_idx    = (last_idx == 4'd9) ? 4'd0 : last_idx + 4'd1;
    end

    always_ff @(posedge clk_28 or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clk7p_en) begin
            case (state_q)
                S_IDLE: if (bus.req) state_d = S_SYNC;
                S_SYNC: begin
                    if (!bus.req) begin
                        state_d = S_IDLE;
                    end else if (hit_vma) begin
                        state_d = S_VMA;
                    end
                end
                S_VMA:  if (hit_e_rise) state_d = S_SEL;
                S_SEL:  if (hit_e_last) state_d = S_DONE;
                S_DONE: if (!bus.req) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs change only on the transition edges; ack is self-clearing on the following edge.
    always_ff @(posedge clk_28 or posedge rst) begin
        if (rst) begin
            bus.vma      <= 1'b0;
            bus.cia_sel  <= 1'b0;
            bus.cia_rnw  <= 1'b1;
            bus.cia_dout <= 8'h00;
            bus.cpu_dout <= 8'h00;
            bus.ack      <= 1'b0;
        end else begin
            bus.ack <= 1'b0;
            if (state_q == S_IDLE && state_d == S_SYNC) begin
                bus.cia_rnw  <= bus.rnw;
                bus.cia_dout <= bus.cpu_din;
            end
            if (state_q == S_SYNC && state_d == S_VMA) begin
                bus.vma <= 1'b1;
            end
            if (state_q == S_VMA && state_d == S_SEL) begin
                bus.cia_sel <= 1'b1;
            end
            if (state_q == S_SEL && state_d == S_DONE) begin
                bus.vma     <= 1'b0;
                bus.cia_sel <= 1'b0;
                bus.ack     <= 1'b1;
                if (bus.cia_rnw) begin
                    bus.cpu_dout <= bus.cia_din;
                end
            end
        end
    end

    always_ff @(posedge clk_28 or posedge rst) begin
        if (rst) begin
            phase_err  <= 1'b0;
            last_idx   <= 4'd0;
            last_valid <= 1'b0;
        end else if (clk7p_en) begin
            if (!eclk_onehot) begin
                phase_err <= 1'b1;
            end else begin
                if (last_valid && phase_idx != exp_idx) begin
                    phase_err <= 1'b1;
                end
                last_idx   <= phase_idx;
                last_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eclk_bus_ctrl.sv
// tb/tb_eclk_bus_ctrl.sv - directed self-checking bench for eclk_bus_ctrl
module tb_eclk_bus_ctrl;

    logic       clk_28;
    logic       rst;
    logic       clk7p_en;
    logic [9:0] eclk;
    logic       phase_err;

    eclk_bus_ctrl_if bus ();

    eclk_bus_ctrl #(.VMA_PHASE(3)) dut (
        .clk_28    (clk_28),
        .rst       (rst),
        .clk7p_en  (clk7p_en),
        .eclk      (eclk),
        .phase_err (phase_err),
        .bus       (bus)
    );

    initial begin
        clk_28 = 1'b0;
        forever #5 clk_28 = ~clk_28;
    end

    int checks = 0;
    int errors = 0;
    int ph     = 0;
    int vma_rise, vma_fall, sel_rise, sel_fall, ack_ph, ack_cnt, vma_any;
    int n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_marks();
        vma_rise = -1; vma_fall = -1; sel_rise = -1; sel_fall = -1;
        ack_ph = -1; ack_cnt = 0; vma_any = 0;
    endtask

    // One 7 MHz tick (4 clk_28 cycles); p < 0 presents a corrupt all-zero eclk.
    task automatic tick(input int p);
        logic v0, s0;
        eclk     = (p < 0) ? 10'd0 : (10'd1 << p);
        clk7p_en = 1'b1;
        v0 = bus.vma;
        s0 = bus.cia_sel;
        @(posedge clk_28); #1;
        clk7p_en = 1'b0;
        if (!v0 && bus.vma) vma_rise = p;
        if (v0 && !bus.vma) vma_fall = p;
        if (!s0 && bus.cia_sel) sel_rise = p;
        if (s0 && !bus.cia_sel) sel_fall = p;
        if (bus.vma) vma_any = 1;
        if (bus.ack) begin ack_cnt++; ack_ph = p; end
        repeat (3) begin
            @(posedge clk_28); #1;
            if (bus.ack) ack_cnt++;
        end
    endtask

    task automatic step();
        tick(ph);
        ph = (ph + 1) % 10;
    endtask

    task automatic run_to_ack(input int max_t, output int cnt);
        int a0;
        a0  = ack_cnt;
        cnt = 0;
        while (ack_cnt == a0 && cnt < max_t) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; clk7p_en = 1'b0; eclk = 10'd1;
        bus.req = 1'b0; bus.rnw = 1'b1; bus.cpu_din = 8'h00; bus.cia_din = 8'h00;
        clear_marks();
        repeat (3) @(posedge clk_28);
        #1;
        check("rst_vma", bus.vma, 0);
        check("rst_sel", bus.cia_sel, 0);
        check("rst_cia_rnw", bus.cia_rnw, 1);
        check("rst_cia_dout", bus.cia_dout, 8'h00);
        check("rst_cpu_dout", bus.cpu_dout, 8'h00);
        check("rst_ack", bus.ack, 0);
        check("rst_perr", phase_err, 0);
        rst = 1'b0;

        // read accepted at phase 2
        step(); step();
        bus.rnw = 1'b1; bus.cia_din = 8'hA5; bus.cpu_din = 8'h11; bus.req = 1'b1;
        clear_marks();
        step();
        check("rd_vma_accept", bus.vma, 0);
        run_to_ack(20, n);
        check("rd_lat", n, 7);
        check("rd_vma_rise", vma_rise, 3);
        check("rd_sel_rise", sel_rise, 6);
        check("rd_vma_fall", vma_fall, 9);
        check("rd_sel_fall", sel_fall, 9);
        check("rd_ack_ph", ack_ph, 9);
        check("rd_ack_width", ack_cnt, 1);
        check("rd_cpu_dout", bus.cpu_dout, 8'hA5);
        bus.req = 1'b0;
        step();

        // write accepted at phase 3 waits a whole period
        step(); step();
        bus.rnw = 1'b0; bus.cpu_din = 8'h3C; bus.cia_din = 8'hFF; bus.req = 1'b1;
        clear_marks();
        step();
        check("wr_cia_rnw", bus.cia_rnw, 0);
        check("wr_cia_dout", bus.cia_dout, 8'h3C);
        run_to_ack(30, n);
        check("wr_lat", n, 16);
        check("wr_vma_rise", vma_rise, 3);
        check("wr_ack_width", ack_cnt, 1);
        check("wr_cpu_dout_held", bus.cpu_dout, 8'hA5);
        check("wr_cia_rnw_end", bus.cia_rnw, 0);
        check("wr_cia_dout_end", bus.cia_dout, 8'h3C);
        bus.req = 1'b0;
        step();

        // aborts: one exactly at the VMA phase tick, one earlier in SYNC
        clear_marks();
        bus.rnw = 1'b1; bus.req = 1'b1;
        step(); step();
        bus.req = 1'b0;
        step();
        check("ab_vma_exact", bus.vma, 0);
        step();
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        repeat (9) step();
        check("ab_vma_any", vma_any, 0);
        check("ab_ack", ack_cnt, 0);

        // req dropped once vma is up: cycle still completes
        repeat (5) step();
        bus.rnw = 1'b1; bus.cia_din = 8'h5A; bus.req = 1'b1;
        clear_marks();
        repeat (4) step();
        check("dr_vma", bus.vma, 1);
        bus.req = 1'b0;
        run_to_ack(20, n);
        check("dr_lat", n, 6);
        check("dr_ack_ph", ack_ph, 9);
        check("dr_cpu_dout", bus.cpu_dout, 8'h5A);
        step();
        check("pe_clean", phase_err, 0);

        // corrupt eclk in SYNC stalls the FSM and latches the error
        bus.rnw = 1'b1; bus.cia_din = 8'hC3; bus.req = 1'b1;
        clear_marks();
        step(); step();
        tick(-1);
        ph = 4;
        check("pe_set", phase_err, 1);
        check("pe_stall_vma", bus.vma, 0);
        run_to_ack(30, n);
        check("pe_lat", n, 16);
        check("pe_cpu_dout", bus.cpu_dout, 8'hC3);
        check("pe_sticky", phase_err, 1);
        bus.req = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("pe_rst_clear", phase_err, 0);
        @(posedge clk_28); #1;
        rst = 1'b0;

        // skip 4 -> 6 after the first sample re-arms the check
        repeat (4) step();
        check("sk_armed", phase_err, 0);
        ph = 6;
        step();
        check("sk_err", phase_err, 1);
        rst = 1'b1;
        @(posedge clk_28); #1;
        rst = 1'b0;
        check("sk_rst_clear", phase_err, 0);

        // reset in the middle of SEL, then a fresh read
        repeat (3) step();
        bus.rnw = 1'b0; bus.cpu_din = 8'h77; bus.req = 1'b1;
        step();
        repeat (7) step();
        check("sr_sel_pre", bus.cia_sel, 1);
        check("sr_vma_pre", bus.vma, 1);
        @(negedge clk_28);
        rst = 1'b1;
        #1;
        check("sr_vma", bus.vma, 0);
        check("sr_sel", bus.cia_sel, 0);
        check("sr_cia_rnw", bus.cia_rnw, 1);
        check("sr_cia_dout", bus.cia_dout, 8'h00);
        check("sr_cpu_dout", bus.cpu_dout, 8'h00);
        check("sr_ack", bus.ack, 0);
        bus.req = 1'b0;
        @(posedge clk_28); #1;
        rst = 1'b0;
        clear_marks();
        repeat (4) step();
        bus.rnw = 1'b1; bus.cia_din = 8'h96; bus.req = 1'b1;
        step();
        run_to_ack(20, n);
        check("sr2_lat", n, 7);
        check("sr2_cpu_dout", bus.cpu_dout, 8'h96);
        check("sr2_ack_cnt", ack_cnt, 1);
        check("sr2_perr", phase_err, 0);
        bus.req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
